// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions: opcodes, one-hot T-state encodings and control-word bit positions.
package sap1_pkg;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_JZ  = 4'h3;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam int T_W = 6;
    localparam logic [T_W-1:0] T1 = 6'b000001;
    localparam logic [T_W-1:0] T2 = 6'b000010;
    localparam logic [T_W-1:0] T3 = 6'b000100;
    localparam logic [T_W-1:0] T4 = 6'b001000;
    localparam logic [T_W-1:0] T5 = 6'b010000;
    localparam logic [T_W-1:0] T6 = 6'b100000;

    localparam int CW_PC_OUT     = 0;
    localparam int CW_PC_INC     = 1;
    localparam int CW_PC_LOAD    = 2;
    localparam int CW_MAR_LOAD   = 3;
    localparam int CW_RAM_OUT    = 4;
    localparam int CW_IR_LOAD    = 5;
    localparam int CW_IR_OUT     = 6;
    localparam int CW_ACC_LOAD   = 7;
    localparam int CW_ACC_OUT_EN = 8;
    localparam int CW_B_LOAD     = 9;
    localparam int CW_ALU_SUB    = 10;
    localparam int CW_ALU_OUT_EN = 11;
    localparam int CW_OUT_LOAD   = 12;
    localparam int CW_W          = 13;

    typedef logic [CW_W-1:0] ctrl_word_t;

    // Run/halt mode of the sequencer; HALTED is sticky until reset.
    typedef enum logic {
        MODE_RUN    = 1'b0,
        MODE_HALTED = 1'b1
    } mode_e;

endpackage

// File: rtl/t_ring_counter.sv
// Six-position one-hot T-state ring; rotates on advance unless frozen.
module t_ring_counter
    import sap1_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           advance,
    input  logic           freeze,
    output logic [T_W-1:0] ring
);

    logic [T_W-1:0] ring_q;
    logic [T_W-1:0] ring_d;

    always_comb begin
        ring_d = ring_q;
        if (advance && !freeze) begin
            ring_d = {ring_q[T_W-2:0], ring_q[T_W-1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ring_q <= T1;
        end else begin
            ring_q <= ring_d;
        end
    end

    assign ring = ring_q;

endmodule

// File: rtl/sap1_controller_sequencer.sv
// SAP-1 controller: step-edge detection, sticky halt and the fetch/execute decode table
// driving every datapath strobe from the current T-state and IR opcode.
module sap1_controller_sequencer
    import sap1_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       step,
    input  logic [3:0] ir_opcode,
    input  logic       zero_flag,
    output logic       pc_out,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       mar_load,
    output logic       ram_out,
    output logic       ir_load,
    output logic       ir_out,
    output logic       acc_load,
    output logic       acc_out_en,
    output logic       b_load,
    output logic       alu_sub,
    output logic       alu_out_en,
    output logic       out_load,
    output logic [5:0] t_state,
    output logic       halted
);

    logic           step_q;
    logic           step_d;
    mode_e          mode_q;
    mode_e          mode_d;
    logic           step_rise;
    logic           advance;
    logic           halt_now;
    logic           freeze;
    logic [T_W-1:0] ring;
    ctrl_word_t     cw;

    always_comb begin
        step_rise = step && !step_q;
        advance   = run || step_rise;
        // HLT latches on the edge that would have left T4, so the ring stays parked at T4.
        halt_now  = (mode_q == MODE_RUN) && advance && (ring == T4) && (ir_opcode == OP_HLT);
        freeze    = (mode_q == MODE_HALTED) || halt_now;
        step_d    = step;
        mode_d    = mode_q;
        if (halt_now) begin
            mode_d = MODE_HALTED;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            step_q <= 1'b0;
            mode_q <= MODE_RUN;
        end else begin
            step_q <= step_d;
            mode_q <= mode_d;
        end
    end

    t_ring_counter u_ring (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (advance),
        .freeze  (freeze),
        .ring    (ring)
    );

    always_comb begin
        cw = '0;
        if (rst_n && (mode_q == MODE_RUN)) begin
            case (ring)
                T1: begin
                    cw[CW_PC_OUT]   = 1'b1;
                    cw[CW_MAR_LOAD] = 1'b1;
                end
                T2: cw[CW_PC_INC] = 1'b1;
                T3: begin
                    cw[CW_RAM_OUT] = 1'b1;
                    cw[CW_IR_LOAD] = 1'b1;
                end
                T4: begin
                    case (ir_opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            cw[CW_IR_OUT]   = 1'b1;
                            cw[CW_MAR_LOAD] = 1'b1;
                        end
                        OP_JZ: begin
                            cw[CW_IR_OUT]  = zero_flag;
                            cw[CW_PC_LOAD] = zero_flag;
                        end
                        OP_OUT: begin
                            cw[CW_ACC_OUT_EN] = 1'b1;
                            cw[CW_OUT_LOAD]   = 1'b1;
                        end
                        default: cw = '0;
                    endcase
                end
                T5: begin
                    case (ir_opcode)
                        OP_LDA: begin
                            cw[CW_RAM_OUT]  = 1'b1;
                            cw[CW_ACC_LOAD] = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            cw[CW_RAM_OUT] = 1'b1;
                            cw[CW_B_LOAD]  = 1'b1;
                            cw[CW_ALU_SUB] = (ir_opcode == OP_SUB);
                        end
                        default: cw = '0;
                    endcase
                end
                T6: begin
                    if ((ir_opcode == OP_ADD) || (ir_opcode == OP_SUB)) begin
                        cw[CW_ALU_OUT_EN] = 1'b1;
                        cw[CW_ACC_LOAD]   = 1'b1;
                        cw[CW_ALU_SUB]    = (ir_opcode == OP_SUB);
                    end
                end
                default: cw = '0;
            endcase
        end
    end

    assign pc_out     = cw[CW_PC_OUT];
    assign pc_inc     = cw[CW_PC_INC];
    assign pc_load    = cw[CW_PC_LOAD];
    assign mar_load   = cw[CW_MAR_LOAD];
    assign ram_out    = cw[CW_RAM_OUT];
    assign ir_load    = cw[CW_IR_LOAD];
    assign ir_out     = cw[CW_IR_OUT];
    assign acc_load   = cw[CW_ACC_LOAD];
    assign acc_out_en = cw[CW_ACC_OUT_EN];
    assign b_load     = cw[CW_B_LOAD];
    assign alu_sub    = cw[CW_ALU_SUB];
    assign alu_out_en = cw[CW_ALU_OUT_EN];
    assign out_load   = cw[CW_OUT_LOAD];

    assign t_state = rst_n ? ring : T1;
    assign halted  = rst_n && (mode_q == MODE_HALTED);

endmodule

// File: tb/tb_sap1_controller_sequencer.sv
// Directed bench for the SAP-1 sequencer: driver pushes the expected {halted, t_state, strobes}
// word per cycle; a negedge monitor pops and compares it against the DUT outputs.
module tb_sap1_controller_sequencer;
    import sap1_pkg::*;

    localparam int W = 1 + T_W + CW_W;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic       step = 1'b0;
    logic [3:0] ir_opcode = 4'h0;
    logic       zero_flag = 1'b0;
    logic       pc_out, pc_inc, pc_load, mar_load, ram_out, ir_load, ir_out;
    logic       acc_load, acc_out_en, b_load, alu_sub, alu_out_en, out_load;
    logic [5:0] t_state;
    logic       halted;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    logic         vec_valid = 1'b0;
    int           n_checks = 0;
    int           n_errors = 0;

    localparam logic [CW_W-1:0] M_PC_OUT   = 13'h0001;
    localparam logic [CW_W-1:0] M_PC_INC   = 13'h0002;
    localparam logic [CW_W-1:0] M_PC_LOAD  = 13'h0004;
    localparam logic [CW_W-1:0] M_MAR_LOAD = 13'h0008;
    localparam logic [CW_W-1:0] M_RAM_OUT  = 13'h0010;
    localparam logic [CW_W-1:0] M_IR_LOAD  = 13'h0020;
    localparam logic [CW_W-1:0] M_IR_OUT   = 13'h0040;
    localparam logic [CW_W-1:0] M_ACC_LOAD = 13'h0080;
    localparam logic [CW_W-1:0] M_ACC_OUT  = 13'h0100;
    localparam logic [CW_W-1:0] M_B_LOAD   = 13'h0200;
    localparam logic [CW_W-1:0] M_ALU_SUB  = 13'h0400;
    localparam logic [CW_W-1:0] M_ALU_OUT  = 13'h0800;
    localparam logic [CW_W-1:0] M_OUT_LOAD = 13'h1000;

    sap1_controller_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .step       (step),
        .ir_opcode  (ir_opcode),
        .zero_flag  (zero_flag),
        .pc_out     (pc_out),
        .pc_inc     (pc_inc),
        .pc_load    (pc_load),
        .mar_load   (mar_load),
        .ram_out    (ram_out),
        .ir_load    (ir_load),
        .ir_out     (ir_out),
        .acc_load   (acc_load),
        .acc_out_en (acc_out_en),
        .b_load     (b_load),
        .alu_sub    (alu_sub),
        .alu_out_en (alu_out_en),
        .out_load   (out_load),
        .t_state    (t_state),
        .halted     (halted)
    );

    // clock
    always #5 clk = ~clk;

    // Hand-written strobe table: fetch T1..T3, then per-opcode execute T4..T6.
    function automatic logic [CW_W-1:0] exp_cw(input logic [3:0] op, input logic zf, input int tidx);
        logic [CW_W-1:0] c;
        c = '0;
        case (tidx)
            1: c = M_PC_OUT | M_MAR_LOAD;
            2: c = M_PC_INC;
            3: c = M_RAM_OUT | M_IR_LOAD;
            4: case (op)
                   4'h0, 4'h1, 4'h2: c = M_IR_OUT | M_MAR_LOAD;
                   4'h3:             c = zf ? (M_IR_OUT | M_PC_LOAD) : '0;
                   4'hE:             c = M_ACC_OUT | M_OUT_LOAD;
                   default:          c = '0;
               endcase
            5: case (op)
                   4'h0:    c = M_RAM_OUT | M_ACC_LOAD;
                   4'h1:    c = M_RAM_OUT | M_B_LOAD;
                   4'h2:    c = M_RAM_OUT | M_B_LOAD | M_ALU_SUB;
                   default: c = '0;
               endcase
            6: case (op)
                   4'h1:    c = M_ALU_OUT | M_ACC_LOAD;
                   4'h2:    c = M_ALU_OUT | M_ACC_LOAD | M_ALU_SUB;
                   default: c = '0;
               endcase
            default: c = '0;
        endcase
        return c;
    endfunction

    // driver: one clock of stimulus plus the expected outputs for that clock
    task automatic cyc(input logic r, input logic rn, input logic st, input logic [3:0] op,
                       input logic zf, input int tidx, input logic hl, input string nm);
        logic [CW_W-1:0] c;
        logic [T_W-1:0]  t;
        logic            h;
        @(posedge clk);
        #1;
        rst_n = r;
        run = rn;
        step = st;
        ir_opcode = op;
        zero_flag = zf;
        if (!r) begin
            t = T1;
            c = '0;
            h = 1'b0;
        end else begin
            t = T1 << (tidx - 1);
            h = hl;
            c = hl ? '0 : exp_cw(op, zf, tidx);
        end
        exp_q.push_back({h, t, c});
        name_q.push_back(nm);
        vec_valid = 1'b1;
    endtask

    task automatic run_instr(input logic [3:0] op, input logic zf, input string nm);
        for (int i = 1; i <= 6; i++) begin
            cyc(1'b1, 1'b1, 1'b0, op, zf, i, 1'b0, nm);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        logic [W-1:0] act;
        logic [W-1:0] exp_w;
        string        nm;
        int           drivers;
        if (vec_valid) begin
            act = {halted, t_state, out_load, alu_out_en, alu_sub, b_load, acc_out_en, acc_load,
                   ir_out, ir_load, ram_out, mar_load, pc_load, pc_inc, pc_out};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL scoreboard_underflow: got word %h, want a queued expectation", act);
            end else begin
                exp_w = exp_q.pop_front();
                nm = name_q.pop_front();
                if (act !== exp_w) begin
                    n_errors++;
                    $display("FAIL %s: got halted=%b t=%h cw=%h, want halted=%b t=%h cw=%h @%0t",
                             nm, act[W-1], act[W-2 -: T_W], act[CW_W-1:0],
                             exp_w[W-1], exp_w[W-2 -: T_W], exp_w[CW_W-1:0], $time);
                end
            end
            drivers = int'(pc_out) + int'(ram_out) + int'(ir_out) + int'(acc_out_en) + int'(alu_out_en);
            n_checks++;
            if (drivers > 1) begin
                n_errors++;
                $display("FAIL bus_excl: got %0d bus drivers, want at most 1 @%0t", drivers, $time);
            end
        end
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want stimulus completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // reset held for two clocks, run high
        cyc(1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1, 1'b0, "reset");
        cyc(1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1, 1'b0, "reset");

        // free-run instruction patterns
        run_instr(4'h0, 1'b0, "lda");
        run_instr(4'h1, 1'b0, "add");
        run_instr(4'h2, 1'b1, "sub");
        run_instr(4'h3, 1'b1, "jz_taken");
        run_instr(4'h3, 1'b0, "jz_not_taken");
        run_instr(4'hE, 1'b0, "out");
        run_instr(4'h7, 1'b1, "undef_nop");

        // every non-halting opcode for bus exclusivity
        for (int op = 0; op < 15; op++) begin
            run_instr(4'(op), 1'($urandom_range(0, 1)), "opcode_sweep");
        end

        // single-step: held step advances once, then three separate pulses
        cyc(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1, 1'b0, "step_idle");
        cyc(1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 1, 1'b0, "step_hold");
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 2, 1'b0, "step_hold");
        end
        cyc(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 2, 1'b0, "step_low");
        cyc(1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 2, 1'b0, "pulse1");
        cyc(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 3, 1'b0, "pulse1_low");
        cyc(1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 3, 1'b0, "pulse2");
        cyc(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4, 1'b0, "pulse2_low");
        cyc(1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 4, 1'b0, "pulse3");
        cyc(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 5, 1'b0, "pulse3_low");
        cyc(1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 5, 1'b0, "resume_run");
        cyc(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 6, 1'b0, "resume_run");

        // reset during T5 of ADD aborts the instruction
        for (int i = 1; i <= 4; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 4'h1, 1'b0, i, 1'b0, "add_pre_rst");
        end
        cyc(1'b0, 1'b1, 1'b0, 4'h1, 1'b0, 5, 1'b0, "rst_mid_add");
        cyc(1'b1, 1'b1, 1'b0, 4'h1, 1'b0, 1, 1'b0, "after_rst");
        for (int i = 2; i <= 6; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 4'h1, 1'b0, i, 1'b0, "add_post_rst");
        end

        // HLT freezes at T4 regardless of run/step, until reset
        for (int i = 1; i <= 4; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 4'hF, 1'b0, i, 1'b0, "hlt_fetch");
        end
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'(i),
                1'($urandom_range(0, 1)), 4, 1'b1, "halted_hold");
        end
        cyc(1'b0, 1'b1, 1'b0, 4'hF, 1'b0, 4, 1'b0, "halt_reset");
        run_instr(4'h0, 1'b0, "lda_after_halt");

        @(posedge clk);
        #1;
        vec_valid = 1'b0;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
